// File: rtl/jk_bank_driver.sv
// jk_bank_driver
//   Upstream controller for a bank of WIDTH JK flip-flops sharing clk. Takes
//   one command at a time over valid/ready. It turns the command into a single
//   cycle of J/K excitation, then reads the bank back and confirms the result.
//   On a mismatch it retries with a direct load, up to MAX_RETRY times. The
//   outcome is reported as a one-cycle done or err pulse.
//
// Ports
//   clk        in   rising-edge clock, shared with the JK bank
//   rst        in   synchronous, active-high reset
//   req_valid  in   command present
//   req_ready  out  block can accept a command (IDLE and not in reset)
//   req_op     in   00 LOAD, 01 TOGGLE, 10 SET, 11 CLEAR
//   req_data   in   LOAD value or bit mask
//   q_fb       in   q outputs of the JK bank
//   j, k       out  registered J/K excitation for the bank
//   busy       out  command in progress
//   done       out  one-cycle pulse: bank matched the expected value
//   err        out  one-cycle pulse: retries exhausted without a match
module jk_bank_driver #(
  parameter int WIDTH     = 4,
  parameter int MAX_RETRY = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [1:0]       req_op,
  input  logic [WIDTH-1:0] req_data,
  input  logic [WIDTH-1:0] q_fb,
  output logic [WIDTH-1:0] j,
  output logic [WIDTH-1:0] k,
  output logic             busy,
  output logic             done,
  output logic             err
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    CHECK = 2'd2
  } state_t;

  localparam logic [1:0] OP_LOAD   = 2'b00;
  localparam logic [1:0] OP_TOGGLE = 2'b01;
  localparam logic [1:0] OP_SET    = 2'b10;
  localparam logic [1:0] OP_CLEAR  = 2'b11;

  localparam logic [2:0] RETRY_LIMIT = 3'(MAX_RETRY);

  state_t           state;
  logic [WIDTH-1:0] expected;
  logic [2:0]       retry_cnt;
  logic             accept;

  // Value the bank must hold once the command has taken effect.
  function automatic logic [WIDTH-1:0] target_value(input logic [1:0]       op,
                                                    input logic [WIDTH-1:0] q,
                                                    input logic [WIDTH-1:0] d);
    case (op)
      OP_LOAD:   target_value = d;
      OP_TOGGLE: target_value = q ^ d;
      OP_SET:    target_value = q | d;
      default:   target_value = q & ~d;
    endcase
  endfunction

  // First-attempt J excitation.
  function automatic logic [WIDTH-1:0] first_j(input logic [1:0]       op,
                                               input logic [WIDTH-1:0] d);
    case (op)
      OP_CLEAR: first_j = '0;
      default:  first_j = d;
    endcase
  endfunction

  // First-attempt K excitation.
  function automatic logic [WIDTH-1:0] first_k(input logic [1:0]       op,
                                               input logic [WIDTH-1:0] d);
    case (op)
      OP_LOAD: first_k = ~d;
      OP_SET:  first_k = '0;
      default: first_k = d;
    endcase
  endfunction

  assign req_ready = (state == IDLE) && !rst;
  assign busy      = (state != IDLE);
  assign accept    = req_valid && req_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      retry_cnt <= '0;
      expected  <= '0;
      j         <= '0;
      k         <= '0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      // J/K are zero outside DRIVE so the bank holds; result flags are pulses.
      j    <= '0;
      k    <= '0;
      done <= 1'b0;
      err  <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            expected  <= target_value(req_op, q_fb, req_data);
            retry_cnt <= '0;
            j         <= first_j(req_op, req_data);
            k         <= first_k(req_op, req_data);
            state     <= DRIVE;
          end
        end
        DRIVE: begin
          state <= CHECK;
        end
        CHECK: begin
          if (q_fb == expected) begin
            done  <= 1'b1;
            state <= IDLE;
          end else if (retry_cnt < RETRY_LIMIT) begin
            // A retry is always a direct load, so it can never re-toggle.
            retry_cnt <= retry_cnt + 3'd1;
            j         <= expected;
            k         <= ~expected;
            state     <= DRIVE;
          end else begin
            err   <= 1'b1;
            state <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_jk_bank_driver.sv
module tb_jk_bank_driver;

  localparam int WIDTH     = 4;
  localparam int MAX_RETRY = 2;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             req_valid = 1'b0;
  logic             req_ready;
  logic [1:0]       req_op = 2'b00;
  logic [WIDTH-1:0] req_data = '0;
  logic [WIDTH-1:0] q_fb;
  logic [WIDTH-1:0] j;
  logic [WIDTH-1:0] k;
  logic             busy;
  logic             done;
  logic             err;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // Behavioural JK bank with an optional stuck-at-0 fault on bit 0 that
  // applies to drive edges while drive_cnt < stuck_until.
  logic [WIDTH-1:0] bank_q = '0;
  logic [WIDTH-1:0] bank_next;
  logic             bank_ld = 1'b0;
  logic [WIDTH-1:0] bank_val = '0;
  int               drive_cnt = 0;
  int               stuck_until = 0;
  logic [WIDTH-1:0] model_q = '0;

  assign q_fb      = bank_q;
  assign bank_next = (j & ~bank_q) | (~k & bank_q);

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    if (bank_ld) begin
      bank_q <= bank_val;
    end else if ((j | k) != '0) begin
      drive_cnt <= drive_cnt + 1;
      if (drive_cnt < stuck_until) bank_q <= {bank_next[WIDTH-1:1], 1'b0};
      else                         bank_q <= bank_next;
    end
  end

  jk_bank_driver #(.WIDTH(WIDTH), .MAX_RETRY(MAX_RETRY)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_data(req_data), .q_fb(q_fb), .j(j), .k(k),
    .busy(busy), .done(done), .err(err)
  );

  task automatic set_bank(input logic [WIDTH-1:0] v);
    @(negedge clk);
    bank_ld  = 1'b1;
    bank_val = v;
    @(negedge clk);
    bank_ld  = 1'b0;
    model_q  = v;
  endtask

  // Issues one command and follows it through to its result pulse.
  // nfail = number of CHECKs the bank fault makes fail (bit 0 stuck at 0).
  task automatic do_cmd(input logic [1:0] op, input logic [WIDTH-1:0] d,
                        input int nfail, input bit hold, output int acc_cyc);
    logic [WIDTH-1:0] q, want, jf, kf, fin;
    int n = 0;
    int a = 0;
    bit finished = 0;
    q = model_q;
    // Reference behaviour: what the bank should become and how it is excited.
    case (op)
      2'b00: begin want = d;      jf = d;  kf = ~d; end
      2'b01: begin want = q ^ d;  jf = d;  kf = d;  end
      2'b10: begin want = q | d;  jf = d;  kf = '0; end
      default: begin want = q & ~d; jf = '0; kf = d; end
    endcase
    acc_cyc = -1;
    while (!req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (!req_ready) begin
      bad++;
      $display("FAIL ready_timeout got=%b want=1", req_ready);
      return;
    end
    req_valid = 1'b1;
    req_op    = op;
    req_data  = d;
    @(posedge clk);
    #1 acc_cyc = cyc;
    @(negedge clk);
    if (!hold) req_valid = 1'b0;
    total++; if (j !== jf) begin bad++; $display("FAIL drive_j op=%0d got=%b want=%b", op, j, jf); end
    total++; if (k !== kf) begin bad++; $display("FAIL drive_k op=%0d got=%b want=%b", op, k, kf); end
    total++; if ({busy, req_ready, done, err} !== 4'b1000) begin bad++; $display("FAIL drive_flags got=%b want=1000", {busy, req_ready, done, err}); end
    while (!finished) begin
      @(negedge clk);
      total++; if ({j, k, done, err, busy} !== {{(2*WIDTH){1'b0}}, 3'b001}) begin bad++; $display("FAIL check_phase j=%b k=%b d=%b e=%b b=%b want j=k=0 busy only", j, k, done, err, busy); end
      @(negedge clk);
      if (a < nfail && a < MAX_RETRY) begin
        total++; if (j !== want || k !== ~want) begin bad++; $display("FAIL retry_jk got j=%b k=%b want j=%b k=%b", j, k, want, ~want); end
        total++; if ({busy, done, err} !== 3'b100) begin bad++; $display("FAIL retry_flags got=%b want=100", {busy, done, err}); end
        a++;
      end else begin
        finished = 1;
        fin = (a < nfail) ? (want & {{(WIDTH-1){1'b1}}, 1'b0}) : want;
        total++; if ({done, err} !== ((a < nfail) ? 2'b01 : 2'b10)) begin bad++; $display("FAIL result got done=%b err=%b want %s", done, err, (a < nfail) ? "err" : "done"); end
        total++; if ({busy, req_ready} !== 2'b01) begin bad++; $display("FAIL result_ready got busy=%b ready=%b want 0 1", busy, req_ready); end
        total++; if (cyc - acc_cyc !== 2 + 2 * a) begin bad++; $display("FAIL latency got=%0d want=%0d", cyc - acc_cyc, 2 + 2 * a); end
        total++; if (q_fb !== fin) begin bad++; $display("FAIL bank_value got=%b want=%b", q_fb, fin); end
        model_q = fin;
      end
    end
    if (!hold) begin
      @(negedge clk);
      total++; if ({done, err, busy} !== 3'b000) begin bad++; $display("FAIL pulse_end got=%b want=000", {done, err, busy}); end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      total++; if ({j, k} !== '0) begin bad++; $display("FAIL reset_jk got j=%b k=%b want 0", j, k); end
      total++; if ({done, err, busy, req_ready} !== 4'b0000) begin bad++; $display("FAIL reset_flags got=%b want=0000", {done, err, busy, req_ready}); end
    end
    rst = 1'b0;
    @(negedge clk);
    total++; if ({req_ready, busy} !== 2'b10) begin bad++; $display("FAIL reset_release got ready=%b busy=%b want 1 0", req_ready, busy); end
  endtask

  task automatic test_load();
    int acc;
    set_bank(4'b0000);
    do_cmd(2'b00, 4'b1010, 0, 0, acc);
  endtask

  task automatic test_back_to_back();
    int acc0, acc1, acc2;
    set_bank(4'b1010);
    do_cmd(2'b01, 4'b0110, 0, 1, acc0);
    do_cmd(2'b10, 4'b0001, 0, 1, acc1);
    do_cmd(2'b11, 4'b1000, 0, 1, acc2);
    req_valid = 1'b0;
    total++; if (acc1 - acc0 !== 3 || acc2 - acc1 !== 3) begin bad++; $display("FAIL b2b_interval got=%0d,%0d want=3,3", acc1 - acc0, acc2 - acc1); end
    total++; if (model_q !== 4'b0101) begin bad++; $display("FAIL b2b_final got=%b want=0101", model_q); end
    @(negedge clk);
    total++; if ({done, busy} !== 2'b00) begin bad++; $display("FAIL b2b_idle got=%b want=00", {done, busy}); end
  endtask

  task automatic test_retry_once();
    int acc;
    set_bank(4'b0000);
    stuck_until = drive_cnt + 1;
    do_cmd(2'b00, 4'b0001, 1, 0, acc);
    stuck_until = 0;
  endtask

  task automatic test_retry_exhaust();
    int acc;
    set_bank(4'b0000);
    stuck_until = drive_cnt + 1000;
    do_cmd(2'b00, 4'b0001, MAX_RETRY + 1, 0, acc);
    stuck_until = 0;
  endtask

  task automatic test_mask_zero();
    int acc;
    set_bank(4'b1001);
    do_cmd(2'b01, 4'b0000, 0, 0, acc);
    do_cmd(2'b10, 4'b0000, 0, 0, acc);
    do_cmd(2'b11, 4'b0000, 0, 0, acc);
  endtask

  task automatic test_reset_mid();
    int n = 0;
    set_bank(4'b0000);
    while (!req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    req_valid = 1'b1;
    req_op    = 2'b00;
    req_data  = 4'b1111;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    total++; if (req_ready !== 1'b0) begin bad++; $display("FAIL mid_ready_in_rst got=%b want=0", req_ready); end
    @(negedge clk);
    total++; if ({done, err, busy, req_ready} !== 4'b0000) begin bad++; $display("FAIL mid_abort got=%b want=0000", {done, err, busy, req_ready}); end
    total++; if ({j, k} !== '0) begin bad++; $display("FAIL mid_jk got j=%b k=%b want 0", j, k); end
    rst = 1'b0;
    @(negedge clk);
    total++; if ({done, err, busy, req_ready} !== 4'b0001) begin bad++; $display("FAIL mid_release got=%b want=0001", {done, err, busy, req_ready}); end
    total++; if (q_fb !== 4'b1111) begin bad++; $display("FAIL mid_bank got=%b want=1111", q_fb); end
    model_q = 4'b1111;
  endtask

  task automatic test_random();
    int acc;
    logic [1:0]       op;
    logic [WIDTH-1:0] d;
    for (int i = 0; i < 24; i++) begin
      op = 2'($urandom_range(0, 3));
      d  = WIDTH'($urandom);
      do_cmd(op, d, 0, (i % 2) == 1, acc);
      req_valid = 1'b0;
    end
  endtask

  initial begin
    test_reset();
    test_load();
    test_back_to_back();
    test_retry_once();
    test_retry_exhaust();
    test_mask_zero();
    test_reset_mid();
    test_random();
    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
